// File: rtl/lab62soc_led_pio_blink.sv
// lab62soc_led_pio_blink: Avalon-MM LED output port with DATA/SET/CLEAR registers and optional blink engine.
// The blink engine, BLINK_MASK, BLINK_PERIOD and STATUS are built only when LED_PIO_BLINK_EN is defined.
module lab62soc_led_pio_blink #(
    parameter int WIDTH = 14,
    parameter int PERIOD_W = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d = !wr             ? data_q :
                 address == 3'd0 ? wd :
                 address == 3'd1 ? data_q | wd :
                 address == 3'd2 ? data_q & ~wd : data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_q <= RESET_VALUE;
        else          data_q <= data_d;
    end

`ifdef LED_PIO_BLINK_EN
    logic [WIDTH-1:0]    mask_q;
    logic [WIDTH-1:0]    mask_d;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] period_d;
    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic                phase_q;
    logic                phase_d;
    logic                per_wr;
    logic                idle;
    logic                wrap;

    assign per_wr = wr && address == 3'd4;
    // a period write restarts the half-period from zero on the same edge
    assign idle   = per_wr || period_q == '0;
    assign wrap   = cnt_q == period_q - PERIOD_W'(1);

    always_comb begin
        mask_d   = (wr && address == 3'd3) ? wd : mask_q;
        period_d = per_wr ? writedata[PERIOD_W-1:0] : period_q;
        cnt_d    = (idle || wrap) ? '0 : cnt_q + PERIOD_W'(1);
        phase_d  = !idle && (phase_q ^ wrap);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign out_port = data_q ^ (mask_q & {WIDTH{phase_q}});

    always_comb begin
        readdata = address == 3'd0 ? 32'(data_q) :
                   address == 3'd3 ? 32'(mask_q) :
                   address == 3'd4 ? 32'(period_q) :
                   address == 3'd5 ? 32'(phase_q) : '0;
    end
`else
    assign out_port = data_q;
    assign readdata = address == 3'd0 ? 32'(data_q) : '0;
`endif
endmodule
